// File: rtl/dec_to_fp_encoder.sv
// -----------------------------------------------------------------------------
// dec_to_fp_encoder
//   Collects an unsigned decimal number one BCD digit at a time, then on a
//   convert request normalises it and encodes it as an IEEE-754 single
//   precision word (round-to-nearest-even), with a one-cycle valid pulse.
//
// Ports
//   clk            system clock, rising edge
//   reset          asynchronous active-low reset
//   digit_valid    a digit is presented this cycle
//   digit          BCD digit value
//   digit_ready    block accepts digits (only while collecting entry)
//   negative       sign of the number, sampled with an accepted convert
//   convert        one-cycle request to encode the entered number
//   busy           conversion in progress (normalise / round)
//   floating_point encoded result, held until the next result
//   fp_valid       one-cycle pulse when floating_point updates
//   entry_err      sticky flag: a digit was rejected since the last result
// -----------------------------------------------------------------------------
module dec_to_fp_encoder #(
    parameter int MAX_DIGITS = 8,
    parameter int ACC_W      = $clog2(10 ** MAX_DIGITS)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        digit_valid,
    input  logic [3:0]  digit,
    output logic        digit_ready,
    input  logic        negative,
    input  logic        convert,
    output logic        busy,
    output logic [31:0] floating_point,
    output logic        fp_valid,
    output logic        entry_err
);

    localparam int CNT_W   = $clog2(MAX_DIGITS + 1);
    localparam int SH_W    = $clog2(ACC_W);
    // Fraction bits below the hidden one; widened to at least 25 so that
    // mantissa (23), guard (1) and sticky (>=1) always have bits to read.
    localparam int FW      = ((ACC_W - 1) > 25) ? (ACC_W - 1) : 25;
    localparam int EXP_TOP = 127 + ACC_W - 1;

    typedef enum logic [1:0] {
        ENTRY = 2'd0,
        NORM  = 2'd1,
        ROUND = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t             state_r;
    state_t             state_s;
    logic [ACC_W-1:0]   acc_r;
    logic [CNT_W-1:0]   count_r;
    logic [SH_W-1:0]    shift_r;
    logic               sign_r;
    logic               busy_r;
    logic [31:0]        fp_r;
    logic               fp_valid_r;
    logic               entry_err_r;

    logic               digit_ok_s;
    logic               digit_bad_s;
    logic [ACC_W-1:0]   acc_mul_s;
    logic               norm_done_s;
    logic [FW-1:0]      frac_ext_s;
    logic [22:0]        mant_s;
    logic               guard_s;
    logic               sticky_s;
    logic               round_up_s;
    logic [23:0]        mant_sum_s;
    logic [7:0]         exp_s;
    logic [7:0]         exp_fin_s;
    logic [31:0]        fp_s;

    assign digit_ready    = (state_r == ENTRY);
    assign busy           = busy_r;
    assign floating_point = fp_r;
    assign fp_valid       = fp_valid_r;
    assign entry_err      = entry_err_r;

    // Digit acceptance and the acc*10+digit update (x10 as x8 + x2).
    always_comb begin
        digit_ok_s  = 1'b0;
        digit_bad_s = 1'b0;
        acc_mul_s   = (acc_r << 3) + (acc_r << 1) + {{(ACC_W-4){1'b0}}, digit};
        if (digit_valid && (state_r == ENTRY)) begin
            if ((digit > 4'd9) || (count_r == CNT_W'(MAX_DIGITS))) begin
                digit_bad_s = 1'b1;
            end else begin
                digit_ok_s = 1'b1;
            end
        end else begin
            digit_ok_s  = 1'b0;
            digit_bad_s = 1'b0;
        end
    end

    // Normalisation ends on zero or once the MSB is set.
    always_comb begin
        norm_done_s = (acc_r == '0) || acc_r[ACC_W-1];
    end

    // Rounding and packing of the normalised accumulator.
    always_comb begin
        frac_ext_s = FW'(acc_r[ACC_W-2:0]) << (FW - (ACC_W - 1));
        mant_s     = frac_ext_s[FW-1 -: 23];
        guard_s    = frac_ext_s[FW-24];
        sticky_s   = |frac_ext_s[FW-25:0];
        round_up_s = guard_s & (sticky_s | mant_s[0]);
        mant_sum_s = {1'b0, mant_s} + {23'd0, round_up_s};
        exp_s      = 8'(EXP_TOP) - 8'(shift_r);
        // A carry out of the mantissa leaves it all-zero and bumps the exponent.
        exp_fin_s  = exp_s + {7'd0, mant_sum_s[23]};
        if (acc_r == '0) begin
            fp_s = {sign_r, 31'd0};
        end else begin
            fp_s = {sign_r, exp_fin_s, mant_sum_s[22:0]};
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ENTRY: begin
                if (convert) begin
                    state_s = NORM;
                end else begin
                    state_s = ENTRY;
                end
            end
            NORM: begin
                if (norm_done_s) begin
                    state_s = ROUND;
                end else begin
                    state_s = NORM;
                end
            end
            ROUND:   state_s = DONE;
            DONE:    state_s = ENTRY;
            default: state_s = ENTRY;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ENTRY;
        end else begin
            state_r <= state_s;
        end
    end

    // Datapath and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_r       <= '0;
            count_r     <= '0;
            shift_r     <= '0;
            sign_r      <= 1'b0;
            busy_r      <= 1'b0;
            fp_r        <= 32'h0000_0000;
            fp_valid_r  <= 1'b0;
            entry_err_r <= 1'b0;
        end else begin
            fp_valid_r <= 1'b0;
            case (state_r)
                ENTRY: begin
                    if (digit_ok_s) begin
                        acc_r   <= acc_mul_s;
                        count_r <= count_r + CNT_W'(1);
                    end
                    if (digit_bad_s) begin
                        entry_err_r <= 1'b1;
                    end
                    if (convert) begin
                        sign_r  <= negative;
                        shift_r <= '0;
                        busy_r  <= 1'b1;
                    end
                end
                NORM: begin
                    if (!norm_done_s) begin
                        acc_r   <= acc_r << 1;
                        shift_r <= shift_r + SH_W'(1);
                    end
                end
                ROUND: begin
                    fp_r       <= fp_s;
                    fp_valid_r <= 1'b1;
                    busy_r     <= 1'b0;
                end
                DONE: begin
                    acc_r       <= '0;
                    count_r     <= '0;
                    entry_err_r <= 1'b0;
                end
                default: begin
                    busy_r <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dec_to_fp_encoder.sv
// -----------------------------------------------------------------------------
// tb_dec_to_fp_encoder
//   Scoreboard bench: each convert pushes its expected word, the monitor pops
//   and compares on every fp_valid pulse. Latency, busy, hold and error flags
//   are checked around each conversion.
// -----------------------------------------------------------------------------
module tb_dec_to_fp_encoder;

    logic        clk = 1'b0;
    logic        reset;
    logic        digit_valid;
    logic [3:0]  digit;
    logic        digit_ready;
    logic        negative;
    logic        convert;
    logic        busy;
    logic [31:0] floating_point;
    logic        fp_valid;
    logic        entry_err;

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] exp_q[$];
    logic [31:0] mon_exp;

    always #5 clk = ~clk;

    dec_to_fp_encoder dut (
        .clk           (clk),
        .reset         (reset),
        .digit_valid   (digit_valid),
        .digit         (digit),
        .digit_ready   (digit_ready),
        .negative      (negative),
        .convert       (convert),
        .busy          (busy),
        .floating_point(floating_point),
        .fp_valid      (fp_valid),
        .entry_err     (entry_err)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%h want=%h", tag, got, want);
        end
    endtask

    // Scoreboard monitor: every result pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (reset && fp_valid) begin
            if (exp_q.size() == 0) begin
                check_eq("spurious_fp_valid", 32'(exp_q.size()), 32'd1);
            end else begin
                mon_exp = exp_q.pop_front();
                check_eq("fp_result", floating_point, mon_exp);
            end
        end
    end

    // Cycles from accepting convert to fp_valid: leading zeros in 27 bits + 2.
    function automatic int exp_latency(input int v);
        int p;
        if (v == 0) return 2;
        p = 26;
        while (p >= 0 && ((v >> p) & 1) == 0) p--;
        return (26 - p) + 2;
    endfunction

    task automatic send_digit(input logic [3:0] d);
        digit_valid = 1'b1;
        digit       = d;
        @(posedge clk);
        @(negedge clk);
        digit_valid = 1'b0;
    endtask

    task automatic enter_number(input int v);
        int ds[$];
        int t;
        t = v;
        while (t > 0) begin
            ds.push_front(t % 10);
            t = t / 10;
        end
        foreach (ds[i]) send_digit(4'(ds[i]));
    endtask

    task automatic run_convert(input logic neg, input logic with_digit, input logic [3:0] d,
                               input int value, input logic [31:0] exp_fp, input logic disturb);
        int n;
        negative = neg;
        convert  = 1'b1;
        if (with_digit) begin
            digit_valid = 1'b1;
            digit       = d;
        end
        exp_q.push_back(exp_fp);
        @(posedge clk);
        @(negedge clk);
        convert     = 1'b0;
        digit_valid = 1'b0;
        negative    = 1'b0;
        check_eq("busy_after_convert", {31'd0, busy}, 32'd1);
        n = 0;
        while (!fp_valid && n < 200) begin
            if (disturb && n == 3) begin
                digit_valid = 1'b1;
                digit       = 4'd5;
                convert     = 1'b1;
                negative    = ~neg;
            end
            @(posedge clk);
            n++;
            @(negedge clk);
            if (disturb && n == 4) begin
                check_eq("ready_while_busy", {31'd0, digit_ready}, 32'd0);
                check_eq("busy_while_norm", {31'd0, busy}, 32'd1);
                check_eq("err_while_busy", {31'd0, entry_err}, 32'd0);
                digit_valid = 1'b0;
                convert     = 1'b0;
                negative    = 1'b0;
            end
        end
        check_eq("latency", 32'(n), 32'(exp_latency(value)));
        check_eq("busy_in_done", {31'd0, busy}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        check_eq("fp_hold", floating_point, exp_fp);
        check_eq("fp_valid_pulse", {31'd0, fp_valid}, 32'd0);
        check_eq("err_cleared", {31'd0, entry_err}, 32'd0);
        check_eq("ready_after", {31'd0, digit_ready}, 32'd1);
    endtask

    initial begin
        reset       = 1'b0;
        digit_valid = 1'b0;
        digit       = 4'd0;
        negative    = 1'b0;
        convert     = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_fp", floating_point, 32'h0000_0000);
        check_eq("rst_fp_valid", {31'd0, fp_valid}, 32'd0);
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        check_eq("rst_err", {31'd0, entry_err}, 32'd0);
        check_eq("rst_ready", {31'd0, digit_ready}, 32'd1);
        reset = 1'b1;
        @(negedge clk);

        // Basic values and sign.
        enter_number(1);
        run_convert(1'b0, 1'b0, 4'd0, 1, 32'h3F80_0000, 1'b0);
        enter_number(3);
        run_convert(1'b1, 1'b0, 4'd0, 3, 32'hC040_0000, 1'b0);
        enter_number(12345678);
        run_convert(1'b0, 1'b0, 4'd0, 12345678, 32'h4B3C_614E, 1'b0);

        // Rounding boundaries.
        enter_number(16777217);
        run_convert(1'b0, 1'b0, 4'd0, 16777217, 32'h4B80_0000, 1'b0);
        enter_number(16777219);
        run_convert(1'b0, 1'b0, 4'd0, 16777219, 32'h4B80_0002, 1'b0);
        enter_number(33554431);
        run_convert(1'b0, 1'b0, 4'd0, 33554431, 32'h4C00_0000, 1'b0);
        enter_number(99999999);
        run_convert(1'b0, 1'b0, 4'd0, 99999999, 32'h4CBE_BC20, 1'b0);

        // Zero, both signs.
        run_convert(1'b0, 1'b0, 4'd0, 0, 32'h0000_0000, 1'b0);
        run_convert(1'b1, 1'b0, 4'd0, 0, 32'h8000_0000, 1'b0);

        // Illegal digit is rejected and flagged.
        send_digit(4'hA);
        check_eq("err_bad_digit", {31'd0, entry_err}, 32'd1);
        send_digit(4'd5);
        check_eq("err_sticky", {31'd0, entry_err}, 32'd1);
        run_convert(1'b0, 1'b0, 4'd0, 5, 32'h40A0_0000, 1'b0);

        // Ninth digit is rejected.
        enter_number(12345678);
        check_eq("err_eight_ok", {31'd0, entry_err}, 32'd0);
        send_digit(4'd9);
        check_eq("err_ninth", {31'd0, entry_err}, 32'd1);
        run_convert(1'b0, 1'b0, 4'd0, 12345678, 32'h4B3C_614E, 1'b0);

        // Digit and convert in the same cycle.
        run_convert(1'b0, 1'b1, 4'd7, 7, 32'h40E0_0000, 1'b0);

        // Digits and convert during busy are ignored.
        enter_number(1);
        run_convert(1'b0, 1'b0, 4'd0, 1, 32'h3F80_0000, 1'b1);

        // Reset during normalisation aborts without a result.
        enter_number(1);
        convert = 1'b1;
        @(posedge clk);
        @(negedge clk);
        convert = 1'b0;
        repeat (5) @(negedge clk);
        check_eq("busy_before_abort", {31'd0, busy}, 32'd1);
        reset = 1'b0;
        #1;
        check_eq("abort_busy", {31'd0, busy}, 32'd0);
        check_eq("abort_fp", floating_point, 32'h0000_0000);
        check_eq("abort_fp_valid", {31'd0, fp_valid}, 32'd0);
        check_eq("abort_ready", {31'd0, digit_ready}, 32'd1);
        @(negedge clk);
        reset = 1'b1;
        repeat (40) @(negedge clk);
        enter_number(2);
        run_convert(1'b0, 1'b0, 4'd0, 2, 32'h4000_0000, 1'b0);

        check_eq("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
